// File: rtl/sensor_sw_debounce_pkg.sv
// Shared constants and types for the four-channel sensor switch debouncer.
package sensor_sw_debounce_pkg;

  localparam int unsigned NUM_SW = 4;

  // Channel positions within the sw / sw_db / sw_chg vectors
  localparam int unsigned CH_CT = 0;
  localparam int unsigned CH_CL = 1;
  localparam int unsigned CH_OT = 2;
  localparam int unsigned CH_OL = 3;

  typedef enum logic {
    StIdle,
    StPending
  } ch_state_e;

endpackage

// File: rtl/sensor_sw_debounce_ch.sv
// One debounce channel: two-flop synchroniser, stability counter, debounced bit and change strobe.
module sensor_sw_debounce_ch
  import sensor_sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic sw_db_o,
  output logic sw_chg_o,
  output logic pending_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ch_state_e        state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= sw_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  // State is implied by whether the synchronised input disagrees with the accepted level.
  always_comb begin
    state = (s2_q != db_q) ? StPending : StIdle;
    db_d  = db_q;
    chg_d = 1'b0;
    cnt_d = '0;
    unique case (state)
      StIdle: begin
        cnt_d = '0;
      end
      StPending: begin
        if (cnt_q == CntMax) begin
          db_d  = s2_q;
          chg_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign sw_db_o   = db_q;
  assign sw_chg_o  = chg_q;
  // A counter left non-zero after a revert still counts as unsettled until it clears.
  assign pending_o = (state == StPending) || (cnt_q != '0);

endmodule

// File: rtl/sensor_sw_debounce.sv
// Four-channel switch debouncer; instantiates one channel per switch and forms settled.
module sensor_sw_debounce
  import sensor_sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] sw_db,
  output logic [NUM_SW-1:0] sw_chg,
  output logic              settled
);

  logic [NUM_SW-1:0] pending;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    sensor_sw_debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk_i     (clk),
      .rst_i     (rst),
      .sw_i      (sw[i]),
      .sw_db_o   (sw_db[i]),
      .sw_chg_o  (sw_chg[i]),
      .pending_o (pending[i])
    );
  end

  assign settled = ~|pending;

endmodule

// File: tb/tb_sensor_sw_debounce.sv
// Directed bench for sensor_sw_debounce with STABLE_CYCLES=4, CNT_W=3.
module tb_sensor_sw_debounce;
  import sensor_sw_debounce_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] sw_db;
  logic [3:0] sw_chg;
  logic       settled;

  int total = 0;
  int bad   = 0;

  sensor_sw_debounce #(
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .sw_db   (sw_db),
    .sw_chg  (sw_chg),
    .settled (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] db, input logic [3:0] chg,
                         input logic st);
    chk({tag, "_db"}, sw_db, db);
    chk({tag, "_chg"}, sw_chg, chg);
    chk({tag, "_settled"}, {3'b000, settled}, {3'b000, st});
  endtask

  initial begin
    rst = 1'b1;
    sw  = 4'b0000;

    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("reset", 4'b0000, 4'b0000, 1'b1);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("idle", 4'b0000, 4'b0000, 1'b1);
    end

    // Clean step on CT: accepted at E+5, settled low E+1..E+4
    sw[CH_CT] = 1'b1;
    tick();
    chk_all("step_e0", 4'b0000, 4'b0000, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all("step_wait", 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_all("step_accept", 4'b0001, 4'b0001, 1'b1);
    tick();
    chk_all("step_after", 4'b0001, 4'b0000, 1'b1);

    // OT glitch of 3 cycles: counter reaches 3 but input reverts first
    sw[CH_OT] = 1'b1;
    tick();
    tick();
    tick();
    sw[CH_OT] = 1'b0;
    tick();
    chk("glitch_e4_chg", sw_chg, 4'b0000);
    tick();
    chk_all("glitch_e5", 4'b0001, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("glitch_tail", 4'b0001, 4'b0000, 1'b1);
    end

    // CL and OL rise together
    sw[CH_CL] = 1'b1;
    sw[CH_OL] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("multi_wait_db", sw_db, 4'b0001);
      chk("multi_wait_chg", sw_chg, 4'b0000);
    end
    tick();
    chk_all("multi_accept", 4'b1011, 4'b1010, 1'b1);
    tick();
    chk_all("multi_after", 4'b1011, 4'b0000, 1'b1);

    // All fall together
    sw = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fall_wait_chg", sw_chg, 4'b0000);
    end
    tick();
    chk_all("fall_accept", 4'b0000, 4'b1011, 1'b1);
    tick();
    chk_all("fall_after", 4'b0000, 4'b0000, 1'b1);

    // CT bounces every 2 cycles, last rise at iteration 8, then held high
    for (int i = 0; i < 10; i++) begin
      sw[CH_CT] = (((i / 2) % 2) == 0);
      tick();
      chk("bounce_chg", sw_chg, 4'b0000);
      chk("bounce_db", sw_db, 4'b0000);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("bounce_hold_chg", sw_chg, 4'b0000);
    end
    tick();
    chk_all("bounce_accept", 4'b0001, 4'b0001, 1'b1);
    tick();
    chk_all("bounce_after", 4'b0001, 4'b0000, 1'b1);

    // Reset while OL count is 2; pending change is dropped
    sw[CH_OL] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk_all("prerst", 4'b0001, 4'b0000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_edge", 4'b0000, 4'b0000, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("rst_wait_db", sw_db, 4'b0000);
      chk("rst_wait_chg", sw_chg, 4'b0000);
    end
    tick();
    chk_all("rst_accept", 4'b1001, 4'b1001, 1'b1);
    tick();
    chk_all("rst_after", 4'b1001, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_sw_debounce.md
SENSOR_SW_DEBOUNCE -- requirements
Module: sensor_sw_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 1000000: consecutive cycles a synchronised input must differ from the debounced value before it is accepted (10 ms at 100 MHz); legal range 2 to 2^CNT_W.
REQ-002 Parameter CNT_W, default 20: width of each per-channel stability counter.
REQ-003 Port clk, input, 1: the only clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port sw, input, 4: raw asynchronous switches, bit 0 CT, bit 1 CL, bit 2 OT, bit 3 OL.
REQ-006 Port sw_db, output, 4: debounced switch levels, same bit order; feeds the downstream LED-decode logic directly.
REQ-007 Port sw_chg, output, 4: one-cycle per-bit strobe marking that sw_db[i] changed at the last edge.
REQ-008 Port settled, output, 1: high when no channel has a pending, not-yet-accepted change.

Function
REQ-009 Each bit shall pass through a two-flop synchroniser (s1 then s2); no logic shall sit between s1 and s2.
REQ-010 Each channel shall hold a counter cnt[i]; in any cycle where s2[i] equals sw_db[i], cnt[i] shall load 0 at the next edge.
REQ-011 In any cycle where s2[i] differs from sw_db[i] and cnt[i] is below STABLE_CYCLES-1, cnt[i] shall increment by 1 at the next edge.
REQ-012 In any cycle where s2[i] differs from sw_db[i] and cnt[i] equals STABLE_CYCLES-1, the next edge shall load sw_db[i] with s2[i], clear cnt[i] and set sw_chg[i].
REQ-013 Per-channel states: IDLE (cnt=0, s2 equals sw_db) and PENDING (s2 differs from sw_db); PENDING returns to IDLE on acceptance (REQ-012) or on s2 reverting (REQ-010). A revert shall not update sw_db and shall not pulse sw_chg.
REQ-014 Latency: for a clean step on sw[i] captured into s1 at edge E, sw_db[i] and sw_chg[i] shall update at edge E+STABLE_CYCLES+1.
REQ-015 sw_chg[i] shall be high for exactly one cycle per accepted change and 0 in every other cycle.
REQ-016 Channels are independent: simultaneous changes on several bits shall produce simultaneous updates and a multi-bit sw_chg in the same cycle.
REQ-017 A bounce shall restart the count, so the accepted change occurs STABLE_CYCLES+1 edges after the last transition.
REQ-018 cnt[i] shall never exceed STABLE_CYCLES-1 and shall never wrap.
REQ-019 settled shall be combinational: high iff every cnt[i] is 0 and s2 equals sw_db.

Reset
REQ-020 While rst is high at an edge, s1, s2, sw_db, every cnt[i] and sw_chg shall load 0; settled then reads 1.
REQ-021 Reset asserted mid-count shall discard the pending change with no sw_chg pulse; after release, a held-high input shall need the full REQ-014 latency measured from its first post-reset capture.

Structure
REQ-022 A shared package shall hold NUM_SW=4 and the channel indices CH_CT=0, CH_CL=1, CH_OT=2, CH_OL=3.
REQ-023 Sub-module sensor_sw_debounce_ch shall implement one channel (synchroniser, counter, sw_db bit, strobe); the top shall instantiate it NUM_SW times and form settled.

Verification (STABLE_CYCLES=4, CNT_W=3)
REQ-024 Reset with sw=4'b0000, held for 10 cycles -> sw_db=4'b0000, sw_chg=4'b0000 and settled=1 throughout.
REQ-025 sw[0] steps 0->1, captured at edge E -> sw_db=4'b0001 and sw_chg=4'b0001 at edge E+5 only; settled low from E+1 until E+5.
REQ-026 sw[2] high for 3 cycles, then low -> sw_db stays 4'b0000, no sw_chg pulse, settled returns to 1.
REQ-027 sw[1] and sw[3] rise on the same cycle -> sw_db=4'b1010 and sw_chg=4'b1010 at the same edge, one cycle wide.
REQ-028 sw[0] toggles every 2 cycles for 10 cycles, then holds 1 -> exactly one sw_chg[0] pulse, 5 edges after the last transition is captured.
REQ-029 rst pulsed while cnt[3]=2 with sw[3] held 1 -> no pulse, sw_db[3]=0; sw_db[3]=1 at edge R+6 after rst release edge R.
